xadc_drp_arbiter: RTL
=====================

Name: xadc_drp_arbiter

Overview:
Shares the single XADC Dynamic Reconfiguration Port (DRP) between NUM_REQUESTERS clients, for example the sampling adapter and a host config/status path. Each client issues single read or write transactions. The arbiter grants round-robin, issues exactly one DRP access at a time, and returns read data or a timeout error to the granted client. It sits between the XADC IP's DRP pins and all DRP users, in the xadc_dclk domain.

Parameters:
NUM_REQUESTERS, 2, number of client ports (1..8)
TIMEOUT_CYCLES, 64, cycles to wait for xadc_drdy after xadc_den before aborting (>=4)

Ports:
xadc_dclk  in  1  DRP clock; the only clock
xadc_reset  in  1  async active-high reset
req_valid  in  NUM_REQUESTERS  per-client request pending
req_ready  out  NUM_REQUESTERS  one-hot accept pulse; the request is consumed when valid&&ready
req_we  in  NUM_REQUESTERS  1=write, 0=read
req_addr  in  NUM_REQUESTERS*7  packed DRP addresses; client i at [7i+:7]
req_di  in  NUM_REQUESTERS*16  packed write data; client i at [16i+:16]
rsp_valid  out  NUM_REQUESTERS  one-hot single-cycle completion pulse to the originating client
rsp_data  out  16  read data, shared; valid only while any rsp_valid is high
rsp_error  out  1  qualifies rsp_valid: 1=timeout, and rsp_data=0
xadc_daddr  out  7  DRP address
xadc_den  out  1  DRP enable
xadc_dwe  out  1  DRP write enable
xadc_di  out  16  DRP write data
xadc_drdy  in  1  DRP ready
xadc_do  in  16  DRP read data

Behaviour:
- Reset values. All outputs are 0. State is IDLE. The round-robin pointer is 0, so client 0 has highest priority first.
- IDLE: if any req_valid is set, grant the first requester at or after the pointer, in wrapping order.
  - The same cycle: req_ready[g]=1, latch addr/we/di, and set the pointer to g+1 mod NUM_REQUESTERS.
  - Next state: ISSUE.
  - req_ready is combinational from state, pointer and req_valid, and is high only in IDLE.
- ISSUE: drive xadc_den=1 for exactly this one cycle, with xadc_dwe=latched we, xadc_daddr and xadc_di latched. Then go to WAIT.
- WAIT: xadc_den=0, xadc_dwe=0, and the timeout counter increments each cycle.
  - If xadc_drdy: capture xadc_do (reads only; writes return 0), rsp_error=0, go to RESPOND.
  - Else if the counter reaches TIMEOUT_CYCLES-1: rsp_data=0, rsp_error=1, go to RESPOND.
- RESPOND: rsp_valid[g]=1 for one cycle, with registered rsp_data and rsp_error. Then go to IDLE.
  - There is no response backpressure. Clients must accept the pulse.
- Minimum turnaround is 4 cycles per transaction: grant, den, drdy (earliest), respond. A back-to-back requester is re-granted at best every 4 cycles.
- Fairness: a continuously requesting client waits at most NUM_REQUESTERS-1 transactions.
- Only one DRP transaction is ever outstanding. xadc_den never reasserts before xadc_drdy or a timeout.
- A stray xadc_drdy in IDLE, ISSUE or RESPOND is ignored.
- A late xadc_drdy after a timeout is ignored. If it lands in the next transaction's WAIT, it is indistinguishable; TIMEOUT_CYCLES must exceed the worst-case XADC DRP latency.
- If a client deasserts req_valid before being granted, nothing is issued for it. Once granted, a transaction always completes with rsp_valid.
- Simultaneous requests are resolved solely by the pointer. A request arriving in the same cycle IDLE is evaluated is grantable.
- Asynchronous reset mid-transaction: return to IDLE immediately with outputs 0. No rsp_valid is emitted for the aborted transaction.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and is cleared on entry to WAIT.

Decomposition:
- Add to xadc_drp_package:
  - XADC_DRP_ADDR_WIDTH=7; xadc_drp_addr_t must be sized to match.
  - Reuse the existing XADC_DRP_DATA_WIDTH=16.
  - XADC_DRP_DEFAULT_TIMEOUT=64.
  - xadc_drp_arbiter_state_t enum {IDLE, ISSUE, WAIT, RESPOND}.
- One sub-module: xadc_drp_rr_arbiter.
  - Combinational grant from request vector and pointer, outputting one-hot grant and grant index.
  - Holds the registered pointer, updated on an enable input.

Test Plan:
- Single read: client 0 reads 0x03, model drdy 2 cycles after den with xadc_do=0x5A3C -> den high exactly 1 cycle with daddr=0x03, dwe=0; rsp_valid[0] pulse with rsp_data=0x5A3C, rsp_error=0.
- Write: client 1 writes 0x1234 to 0x41 -> one den cycle with dwe=1, daddr=0x41, di=0x1234; rsp_valid[1] pulse with rsp_error=0.
- Contention: both clients hold req_valid for 4 transactions from reset -> grant order 0,1,0,1; never two den without an intervening drdy.
- Timeout: model never raises drdy, TIMEOUT_CYCLES=64 -> rsp_valid[0] with rsp_error=1 and rsp_data=0 exactly 64 cycles after the den cycle. A drdy 10 cycles later produces no response; the next request completes normally.
- Reset mid-WAIT: assert xadc_reset 1 cycle after den -> all outputs 0 asynchronously, no rsp_valid; after release, client 0 is granted first.
- Stray drdy in IDLE with no requests -> no rsp_valid, no den; the state stays IDLE.

Source files
------------

// File: rtl/xadc_drp_package.sv
// xadc_drp_package: shared DRP widths, types and arbiter state encoding
package xadc_drp_package;
  localparam int XADC_DRP_ADDR_WIDTH = 7;
  localparam int XADC_DRP_DATA_WIDTH = 16;
  localparam int XADC_DRP_DEFAULT_TIMEOUT = 64;
  typedef logic [XADC_DRP_ADDR_WIDTH-1:0] xadc_drp_addr_t;
  typedef logic [XADC_DRP_DATA_WIDTH-1:0] xadc_drp_data_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} xadc_drp_arbiter_state_t;
endpackage

// File: rtl/xadc_drp_rr_arbiter.sv
// xadc_drp_rr_arbiter: round-robin grant selection with a registered priority pointer
module xadc_drp_rr_arbiter #(
  parameter int N = 2
) (
  input  logic                                xadc_dclk,
  input  logic                                xadc_reset,
  input  logic [N-1:0]                        req,
  input  logic                                en,
  output logic [N-1:0]                        gnt,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0]  gnt_idx,
  output logic                                any
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [IW-1:0] ptr;
  // scan from the farthest offset back to the pointer so the nearest requester wins
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt_idx = IW'((int'(ptr) + i) % N);
  end
  assign any = |req;
  assign gnt = any ? N'(1) << gnt_idx : '0;
  // move priority to the client just after the one granted
  always_ff @(posedge xadc_dclk or posedge xadc_reset)
    if (xadc_reset) ptr <= '0;
    else if (en) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: shares one XADC DRP among several clients, one access at a time
module xadc_drp_arbiter
  import xadc_drp_package::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int TIMEOUT_CYCLES = XADC_DRP_DEFAULT_TIMEOUT
) (
  input  logic                                          xadc_dclk,
  input  logic                                          xadc_reset,
  input  logic [NUM_REQUESTERS-1:0]                     req_valid,
  output logic [NUM_REQUESTERS-1:0]                     req_ready,
  input  logic [NUM_REQUESTERS-1:0]                     req_we,
  input  logic [NUM_REQUESTERS*XADC_DRP_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQUESTERS*XADC_DRP_DATA_WIDTH-1:0] req_di,
  output logic [NUM_REQUESTERS-1:0]                     rsp_valid,
  output logic [XADC_DRP_DATA_WIDTH-1:0]                rsp_data,
  output logic                                          rsp_error,
  output logic [XADC_DRP_ADDR_WIDTH-1:0]                xadc_daddr,
  output logic                                          xadc_den,
  output logic                                          xadc_dwe,
  output logic [XADC_DRP_DATA_WIDTH-1:0]                xadc_di,
  input  logic                                          xadc_drdy,
  input  logic [XADC_DRP_DATA_WIDTH-1:0]                xadc_do
);
  localparam int IW = NUM_REQUESTERS > 1 ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  // the wait ends when the counter is about to reach TIMEOUT_CYCLES-1, so the
  // error response lands exactly TIMEOUT_CYCLES cycles after the den cycle
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);
  xadc_drp_arbiter_state_t state, state_d;
  logic [NUM_REQUESTERS-1:0] gnt;
  logic [IW-1:0] gnt_idx, idx_q;
  logic any, take, tmo, we_q, err_q;
  logic [CW-1:0] cnt;
  xadc_drp_addr_t addr_q;
  xadc_drp_data_t di_q, data_q;
  assign take = state == IDLE && any;
  assign tmo = cnt == CNT_LAST;
  xadc_drp_rr_arbiter #(.N(NUM_REQUESTERS)) u_rr (
    .xadc_dclk (xadc_dclk),
    .xadc_reset(xadc_reset),
    .req       (req_valid),
    .en        (take),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any       (any)
  );
  // state register
  always_ff @(posedge xadc_dclk or posedge xadc_reset)
    if (xadc_reset) state <= IDLE;
    else state <= state_d;
  // one DRP access in flight: grant, strobe den once, wait for drdy or timeout, respond
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = any ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (xadc_drdy || tmo) ? RESPOND : WAIT;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // latch the granted request, run the wait counter and capture the result
  always_ff @(posedge xadc_dclk or posedge xadc_reset)
    if (xadc_reset) begin
      addr_q <= '0;
      di_q <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      cnt <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (take) begin
        addr_q <= req_addr[gnt_idx*XADC_DRP_ADDR_WIDTH +: XADC_DRP_ADDR_WIDTH];
        di_q <= req_di[gnt_idx*XADC_DRP_DATA_WIDTH +: XADC_DRP_DATA_WIDTH];
        we_q <= req_we[gnt_idx];
        idx_q <= gnt_idx;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && (xadc_drdy || tmo)) begin
        data_q <= (xadc_drdy && !we_q) ? xadc_do : '0;
        err_q <= !xadc_drdy;
      end
    end
  assign req_ready = state == IDLE ? gnt : '0;
  assign xadc_den = state == ISSUE;
  assign xadc_dwe = state == ISSUE && we_q;
  assign xadc_daddr = addr_q;
  assign xadc_di = di_q;
  assign rsp_valid = state == RESPOND ? NUM_REQUESTERS'(1) << idx_q : '0;
  assign rsp_data = state == RESPOND ? data_q : '0;
  assign rsp_error = state == RESPOND && err_q;
endmodule
